uart_rx_ctrl: RTL
=================

Name: uart_rx_ctrl

Overview:
- Sequencing/buffering controller for the oversampling UART receiver core.
- Generates the receiver's sample-enable strobe from a runtime baud divisor.
- Captures each completed byte into a show-ahead FIFO with valid/ready output; tracks overrun and frame-error status.
- Sits between the receiver core (enable/done/err/data) and the bus-side consumer.

Parameters:
- Oversample, 16, samples per bit the core uses; informational, divisor is computed by software as clk/(baud*Oversample).
- Depth, 8, FIFO entries; power of two, >=2.
- DivWidth, 16, divisor width.
- ErrCntWidth, 8, frame-error counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run control; 0 stops strobes.
- divisor  in  DivWidth  clocks per sample strobe.
- rxEn  out  1  sample strobe to receiver core.
- rxDone  in  1  core byte-complete pulse, meaningful only while rxEn=1.
- rxErr  in  1  core framing-error pulse, meaningful only while rxEn=1.
- rxData  in  8  core data register, valid from the cycle after an accepted rxDone.
- outData  out  8  FIFO head.
- outValid  out  1  FIFO non-empty.
- outReady  in  1  consumer accepts head.
- level  out  $clog2(Depth)+1  FIFO occupancy.
- overrun  out  1  sticky: byte dropped because FIFO full.
- errCount  out  ErrCntWidth  saturating frame-error count.
- clearStatus  in  1  clears overrun and errCount.

Behaviour:
- Reset values: rxEn=0, outValid=0, level=0, overrun=0, errCount=0, outData=0, FIFO empty. Tick counter loads 0; capture FSM in IDLE.
- Tick generator:
  - Down-counter. When enable=1 and counter==0: rxEn=1 for that cycle and counter reloads divisor-1; otherwise the counter decrements.
  - divisor of 0 or 1 gives rxEn=1 every enabled cycle.
  - A divisor change takes effect at the next reload only.
  - enable=0: rxEn=0 and counter forced to 0, so the first strobe comes in the first cycle after enable rises.
- Capture FSM, states IDLE and PEND:
  - IDLE -> PEND when rxDone&&rxEn.
  - PEND: push rxData into the FIFO, then -> IDLE unconditionally. This gives one-cycle latency from done to push, and two cycles from done to outValid on an empty FIFO.
  - A PEND push completes even if enable drops in that cycle.
- FIFO (show-ahead):
  - outData = head, outValid = level!=0.
  - Pop when outValid&&outReady.
  - Push when full without a simultaneous pop: byte dropped, overrun<=1, contents unchanged.
  - Push when full with a simultaneous pop: push accepted, level unchanged.
  - Push and pop when empty: push only (outValid rises next cycle).
  - Pointers wrap modulo Depth; level is computed from pointers with an extra wrap bit.
- Error counter:
  - Increments on rxErr&&rxEn and saturates at 2^ErrCntWidth-1 (no wrap).
- clearStatus:
  - Zeroes overrun and errCount.
  - An event in the same cycle is applied after the clear: errCount=1, or overrun=1.
- Reset mid-frame or mid-push: everything returns to reset values immediately (asynchronous); FIFO contents are discarded.
- rxDone/rxErr pulses while rxEn=0 are ignored.

Decomposition:
- Shared package uart_pkg:
  - byte_t (8-bit data type).
  - DEFAULT_OVERSAMPLE=16.
  - cap_state_t enum {IDLE, PEND}.
- One sub-module: uart_fifo.
  - Parameterised sync show-ahead FIFO: push/pop/full/empty/level, same clk/reset.
  - Instantiated once.
- Tick generator and status logic stay inline.

Test Plan:
- Strobe rate: divisor=4, enable=1 for 20 cycles -> rxEn high on cycles 1,5,9,13,17 after enable; divisor=1 -> rxEn every cycle; enable=0 -> rxEn=0 and no strobes.
- Byte capture: rxDone pulse with rxEn=1, rxData=0xA5 next cycle, outReady=0 -> outValid=1 and outData=0xA5 two cycles after done; level=1.
- Overrun: Depth=8, push 9 bytes 0x01..0x09 with outReady=0 -> level=8, overrun=1, pops return 0x01..0x08 in order. Then clearStatus -> overrun=0.
- Full-simultaneous: FIFO full, push 0x55 in the same cycle as a pop -> no overrun, level stays 8, last entry popped is 0x55.
- Error counting: 3 rxErr pulses with rxEn=1 and 1 with rxEn=0 -> errCount=3. ErrCntWidth=2 with 5 pulses -> errCount=3 (saturated). clearStatus coincident with an err -> errCount=1.
- Async reset: assert reset while level=5 and state=PEND -> same-cycle outValid=0, level=0, rxEn=0; after release the first push lands at index 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive controller.
package uart_pkg;
  typedef logic [7:0] byte_t;
  localparam int DEFAULT_OVERSAMPLE = 16;
  typedef enum logic {IDLE, PEND} cap_state_t;
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous show-ahead byte FIFO with wrap-bit pointers.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int Depth = 8,
  localparam int AW = $clog2(Depth)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  byte_t       wdata,
  output byte_t       rdata,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level
);
  byte_t mem_q [Depth];
  logic [AW:0] wr_q, rd_q;
  logic pop_ok, wr_ok;
  assign level  = wr_q - rd_q;
  assign empty  = wr_q == rd_q;
  assign full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_ok = pop && !empty;
  // a full FIFO still takes a push when the head leaves in the same cycle
  assign wr_ok  = push && (!full || pop_ok);
  assign rdata  = empty ? '0 : mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok) rd_q <= rd_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sample-strobe generator, byte capture FIFO and status for the UART receiver core.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int Oversample  = DEFAULT_OVERSAMPLE,
  parameter int Depth       = 8,
  parameter int DivWidth    = 16,
  parameter int ErrCntWidth = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [DivWidth-1:0]    divisor,
  output logic                   rxEn,
  input  logic                   rxDone,
  input  logic                   rxErr,
  input  logic [7:0]             rxData,
  output logic [7:0]             outData,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [$clog2(Depth):0] level,
  output logic                   overrun,
  output logic [ErrCntWidth-1:0] errCount,
  input  logic                   clearStatus
);
  logic [DivWidth-1:0] cnt_q, cnt_d;
  cap_state_t state_q, state_d;
  logic [ErrCntWidth-1:0] err_q, err_d;
  logic ovr_q, ovr_d, push, pop, full, empty, err_ev;
  assign rxEn     = enable && !reset && cnt_q == '0;
  assign err_ev   = rxErr && rxEn;
  assign push     = state_q == PEND;
  assign outValid = !empty;
  assign pop      = outValid && outReady;
  assign overrun  = ovr_q;
  assign errCount = err_q;
  always_comb begin
    cnt_d   = !enable ? '0 : rxEn ? (divisor > 1 ? divisor - 1'b1 : '0) : cnt_q - 1'b1;
    state_d = (state_q == IDLE && rxDone && rxEn) ? PEND : IDLE;
    ovr_d   = (ovr_q && !clearStatus) || (push && full && !pop);
    // clear first, then let a coincident error count from zero
    err_d   = clearStatus ? ErrCntWidth'(err_ev) : err_q + ErrCntWidth'(err_ev && !(&err_q));
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      state_q <= IDLE;
      err_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end
  uart_fifo #(.Depth(Depth)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (rxData),
    .rdata (outData),
    .full  (full),
    .empty (empty),
    .level (level)
  );
endmodule
